// File: rtl/sha256_message_build.sv
// SHA-256 message padder: turns a length-tagged stream of 512-bit message blocks into
// padded blocks (0x80 marker, zero fill, 64-bit length) ready for the compression core.
module sha256_message_build #(
    parameter int ID_W   = 6,
    parameter int SIZE_W = 64
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              en,
    input  logic              sync_rst,
    input  logic [SIZE_W-1:0] cfg_size,
    input  logic [ID_W-1:0]   cfg_id,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [511:0]      data_in,
    input  logic              data_in_last,
    input  logic              data_in_valid,
    output logic              data_in_ready,
    output logic [511:0]      data_out,
    output logic [ID_W-1:0]   data_out_id,
    output logic              data_out_last,
    output logic              data_out_valid,
    input  logic              data_out_ready,
    output logic              err_last
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PAD_LEN
    } state_t;

    localparam logic [511:0] ONES   = '1;
    localparam logic [511:0] TOPBIT = {1'b1, 511'd0};

    state_t            state_q, state_d;
    logic [SIZE_W-1:0] rem_q, rem_d;
    logic [SIZE_W-1:0] len_q, len_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              pad_done_q, pad_done_d;
    logic [511:0]      dout_q, dout_d;
    logic [ID_W-1:0]   dout_id_q, dout_id_d;
    logic              dout_last_q, dout_last_d;
    logic              dout_valid_q, dout_valid_d;
    logic              err_q, err_d;

    logic              active;
    logic              out_free;
    logic              cfg_fire;
    logic              din_fire;
    logic              pad_fire;
    logic              rem_gt_blk;
    logic              rem_eq_blk;
    logic              rem_fits_len;
    logic              rem_le_blk;
    logic [8:0]        shamt;
    logic [511:0]      keep_mask;
    logic [511:0]      marker;
    logic [63:0]       len64;
    logic [511:0]      len_field;

    // Handshake qualifiers; nrst gating keeps the ready outputs low while held in reset.
    assign active   = en && !sync_rst && nrst;
    assign out_free = !dout_valid_q || data_out_ready;

    assign cfg_ready     = active && (state_q == S_IDLE);
    assign data_in_ready = active && (state_q == S_DATA) && out_free;

    assign cfg_fire = cfg_valid && cfg_ready;
    assign din_fire = data_in_valid && data_in_ready;
    assign pad_fire = active && (state_q == S_PAD_LEN) && out_free;

    assign rem_gt_blk   = rem_q > SIZE_W'(512);
    assign rem_eq_blk   = rem_q == SIZE_W'(512);
    assign rem_le_blk   = !rem_gt_blk;
    assign rem_fits_len = rem_q < SIZE_W'(448);

    // Only meaningful when rem < 512, i.e. on the final partial block.
    assign shamt     = rem_q[8:0];
    assign keep_mask = ~(ONES >> shamt);
    assign marker    = TOPBIT >> shamt;
    assign len64     = 64'(len_q);
    assign len_field = {448'd0, len64};

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        len_d        = len_q;
        id_d         = id_q;
        pad_done_d   = pad_done_q;
        dout_d       = dout_q;
        dout_id_d    = dout_id_q;
        dout_last_d  = dout_last_q;
        dout_valid_d = dout_valid_q;
        err_d        = err_q;

        if (active) begin
            err_d = 1'b0;
            if (data_out_ready) begin
                dout_valid_d = 1'b0;
            end

            unique case (state_q)
                S_IDLE: begin
                    if (cfg_fire) begin
                        rem_d      = cfg_size;
                        len_d      = cfg_size;
                        id_d       = cfg_id;
                        pad_done_d = 1'b0;
                        state_d    = (cfg_size == '0) ? S_PAD_LEN : S_DATA;
                    end
                end

                S_DATA: begin
                    if (din_fire) begin
                        dout_valid_d = 1'b1;
                        dout_id_d    = id_q;
                        err_d        = (data_in_last != rem_le_blk);
                        if (rem_gt_blk) begin
                            dout_d      = data_in;
                            dout_last_d = 1'b0;
                            rem_d       = rem_q - SIZE_W'(512);
                        end else if (rem_eq_blk) begin
                            dout_d      = data_in;
                            dout_last_d = 1'b0;
                            pad_done_d  = 1'b0;
                            state_d     = S_PAD_LEN;
                        end else if (rem_fits_len) begin
                            dout_d      = (data_in & keep_mask) | marker | len_field;
                            dout_last_d = 1'b1;
                            state_d     = S_IDLE;
                        end else begin
                            // Marker fits but the length field does not: spill to an extra block.
                            dout_d      = (data_in & keep_mask) | marker;
                            dout_last_d = 1'b0;
                            pad_done_d  = 1'b1;
                            state_d     = S_PAD_LEN;
                        end
                    end
                end

                S_PAD_LEN: begin
                    if (pad_fire) begin
                        dout_valid_d = 1'b1;
                        dout_id_d    = id_q;
                        dout_d       = {~pad_done_q, 447'd0, len64};
                        dout_last_d  = 1'b1;
                        state_d      = S_IDLE;
                    end
                end

                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= S_IDLE;
            rem_q        <= '0;
            len_q        <= '0;
            id_q         <= '0;
            pad_done_q   <= 1'b0;
            dout_q       <= '0;
            dout_id_q    <= '0;
            dout_last_q  <= 1'b0;
            dout_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else if (sync_rst) begin
            state_q      <= S_IDLE;
            rem_q        <= '0;
            len_q        <= '0;
            id_q         <= '0;
            pad_done_q   <= 1'b0;
            dout_q       <= '0;
            dout_id_q    <= '0;
            dout_last_q  <= 1'b0;
            dout_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            len_q        <= len_d;
            id_q         <= id_d;
            pad_done_q   <= pad_done_d;
            dout_q       <= dout_d;
            dout_id_q    <= dout_id_d;
            dout_last_q  <= dout_last_d;
            dout_valid_q <= dout_valid_d;
            err_q        <= err_d;
        end
    end

    assign data_out       = dout_q;
    assign data_out_id    = dout_id_q;
    assign data_out_last  = dout_last_q;
    assign data_out_valid = dout_valid_q;
    assign err_last       = err_q;

endmodule

// File: tb/tb_sha256_message_build.sv
// Bench for sha256_message_build: a bit-level padding model builds the expected block
// stream per message; a per-cycle monitor checks outputs, stall stability and err_last.
`timescale 1ns/1ps
module tb_sha256_message_build;
    localparam int ID_W   = 6;
    localparam int SIZE_W = 64;

    logic              clk = 1'b0;
    logic              nrst;
    logic              en;
    logic              sync_rst;
    logic [SIZE_W-1:0] cfg_size;
    logic [ID_W-1:0]   cfg_id;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [511:0]      data_in;
    logic              data_in_last;
    logic              data_in_valid;
    logic              data_in_ready;
    logic [511:0]      data_out;
    logic [ID_W-1:0]   data_out_id;
    logic              data_out_last;
    logic              data_out_valid;
    logic              data_out_ready = 1'b1;
    logic              err_last;

    always #5 clk = ~clk;

    sha256_message_build #(.ID_W(ID_W), .SIZE_W(SIZE_W)) dut (
        .clk(clk), .nrst(nrst), .en(en), .sync_rst(sync_rst),
        .cfg_size(cfg_size), .cfg_id(cfg_id), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .data_in(data_in), .data_in_last(data_in_last), .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready), .data_out(data_out), .data_out_id(data_out_id),
        .data_out_last(data_out_last), .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready), .err_last(err_last)
    );

    typedef struct {
        logic [511:0]    data;
        logic [ID_W-1:0] id;
        logic            last;
    } blk_t;

    blk_t         exp_q[$];
    logic [511:0] log_data[$];
    logic         log_last[$];
    logic [511:0] msg[4];

    int n_assert = 0;
    int n_fail   = 0;
    int err_seen = 0;

    logic rand_rdy = 1'b0;
    logic rdy_fix  = 1'b1;

    // Monitor state
    logic         stall_prev = 1'b0;
    logic [511:0] prev_data;
    logic [ID_W-1:0] prev_id;
    logic         prev_last;
    logic         exp_err = 1'b0;
    int           nin = 0;
    int           in_idx = 0;

    always @(posedge clk) begin
        #1;
        data_out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fix;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk512(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Padded message = M || 1 || 0* || L(64), cut into 512-bit blocks, MSB first.
    task automatic model_push(input logic [63:0] L, input logic [ID_W-1:0] id);
        longint unsigned nb, base, g;
        blk_t b;
        logic v;
        nb   = (longint'(L) + 65 + 511) / 512;
        base = nb * 512 - 64;
        for (longint unsigned k = 0; k < nb; k++) begin
            b.data = '0;
            for (int j = 0; j < 512; j++) begin
                g = k * 512 + longint'(j);
                if (g < L)            v = msg[int'(k)][511 - j];
                else if (g == L)      v = 1'b1;
                else if (g >= base)   v = L[int'(63 - (g - base))];
                else                  v = 1'b0;
                b.data[511 - j] = v;
            end
            b.id   = id;
            b.last = (k == nb - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic mon_step();
        blk_t e;
        if (!nrst) begin
            exp_q.delete();
            stall_prev = 1'b0;
            exp_err    = 1'b0;
            return;
        end
        chk("err_last", 64'(err_last), 64'(exp_err));
        if (err_last) err_seen++;
        if (stall_prev) begin
            chk("stall_valid", 64'(data_out_valid), 64'd1);
            chk512("stall_data", data_out, prev_data);
            chk("stall_id", 64'(data_out_id), 64'(prev_id));
            chk("stall_last", 64'(data_out_last), 64'(prev_last));
        end
        if (en && data_out_valid && data_out_ready) begin
            if (exp_q.size() == 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL unexpected_block: got %h expected none", data_out);
            end else begin
                e = exp_q.pop_front();
                chk512("out_data", data_out, e.data);
                chk("out_id", 64'(data_out_id), 64'(e.id));
                chk("out_last", 64'(data_out_last), 64'(e.last));
                log_data.push_back(data_out);
                log_last.push_back(data_out_last);
            end
        end
        if (sync_rst) begin
            exp_q.delete();
            exp_err    = 1'b0;
            stall_prev = 1'b0;
        end else if (en) begin
            stall_prev = data_out_valid && !data_out_ready;
            prev_data  = data_out;
            prev_id    = data_out_id;
            prev_last  = data_out_last;
            exp_err    = 1'b0;
            if (data_in_valid && data_in_ready) begin
                exp_err = (data_in_last != (in_idx == nin - 1));
                in_idx++;
            end
            if (cfg_valid && cfg_ready) begin
                model_push(cfg_size, cfg_id);
                nin    = int'((cfg_size + 511) / 512);
                in_idx = 0;
            end
        end else begin
            stall_prev = data_out_valid;
            prev_data  = data_out;
            prev_id    = data_out_id;
            prev_last  = data_out_last;
        end
    endtask

    task automatic cfg_send(input logic [63:0] L, input logic [ID_W-1:0] id);
        bit ok = 0;
        @(posedge clk); #1;
        cfg_size  = L;
        cfg_id    = id;
        cfg_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cfg_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            n_assert++; n_fail++;
            $display("FAIL cfg_timeout: got cfg_ready 0 expected 1");
        end else begin
            @(posedge clk); #1;
        end
        cfg_valid = 1'b0;
    endtask

    task automatic blk_send(input int k, input logic last);
        bit ok = 0;
        @(posedge clk); #1;
        data_in       = msg[k];
        data_in_last  = last;
        data_in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (data_in_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            n_assert++; n_fail++;
            $display("FAIL data_timeout: got data_in_ready 0 expected 1");
        end else begin
            @(posedge clk); #1;
        end
        data_in_valid = 1'b0;
        data_in_last  = 1'b0;
    endtask

    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !data_out_valid) begin ok = 1; break; end
        end
        if (!ok) begin
            n_assert++; n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk512({nm, "_data"}, data_out, 512'd0);
        chk({nm, "_valid"}, 64'(data_out_valid), 64'd0);
        chk({nm, "_last"}, 64'(data_out_last), 64'd0);
        chk({nm, "_id"}, 64'(data_out_id), 64'd0);
        chk({nm, "_cfg_ready"}, 64'(cfg_ready), 64'd0);
        chk({nm, "_in_ready"}, 64'(data_in_ready), 64'd0);
        chk({nm, "_err"}, 64'(err_last), 64'd0);
    endtask

    task automatic main_seq();
        int n0, e0;
        logic [511:0] m448;
        nrst = 1'b0; en = 1'b1; sync_rst = 1'b0;
        cfg_size = '0; cfg_id = '0; cfg_valid = 1'b0;
        data_in = '0; data_in_last = 1'b0; data_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        nrst = 1'b1;

        // "abc", garbage beyond L must be masked
        msg[0] = rnd512();
        msg[0][511:488] = 24'h616263;
        n0 = log_data.size();
        cfg_send(64'd24, 6'd5);
        blk_send(0, 1'b1);
        drain();
        chk("abc_count", 64'(log_data.size() - n0), 64'd1);
        if (log_data.size() > n0) begin
            chk512("abc_block", log_data[n0], {32'h61626380, 416'd0, 64'h18});
            chk("abc_last", 64'(log_last[n0]), 64'd1);
        end

        // L=512 with clock-enable gating and a stalled output
        rdy_fix = 1'b0;
        @(posedge clk); #1; en = 1'b0;
        @(negedge clk);
        chk("en0_cfg_ready", 64'(cfg_ready), 64'd0);
        @(posedge clk); #1; en = 1'b1;
        msg[0] = rnd512();
        n0 = log_data.size();
        cfg_send(64'd512, 6'd9);
        @(posedge clk); #1; en = 1'b0;
        @(negedge clk);
        chk("en0_in_ready", 64'(data_in_ready), 64'd0);
        @(posedge clk); #1; en = 1'b1;
        blk_send(0, 1'b1);
        repeat (3) @(negedge clk);
        @(posedge clk); #1; en = 1'b0;
        @(negedge clk);
        chk("en0_valid_held", 64'(data_out_valid), 64'd1);
        @(posedge clk); #1; en = 1'b1;
        rdy_fix = 1'b1;
        drain();
        chk("l512_count", 64'(log_data.size() - n0), 64'd2);
        if (log_data.size() >= n0 + 2) begin
            chk512("l512_blk1", log_data[n0], msg[0]);
            chk("l512_last1", 64'(log_last[n0]), 64'd0);
            chk512("l512_blk2", log_data[n0+1], {1'b1, 447'd0, 64'd512});
            chk("l512_last2", 64'(log_last[n0+1]), 64'd1);
        end

        // L=448: marker fits, length spills to a second block
        msg[0] = rnd512();
        m448 = (msg[0] & {{448{1'b1}}, 64'd0}) | (512'd1 << 63);
        n0 = log_data.size();
        cfg_send(64'd448, 6'd3);
        blk_send(0, 1'b1);
        drain();
        chk("l448_count", 64'(log_data.size() - n0), 64'd2);
        if (log_data.size() >= n0 + 2) begin
            chk512("l448_blk1", log_data[n0], m448);
            chk512("l448_blk2", log_data[n0+1], {448'd0, 64'd448});
        end

        // L=0: config only
        n0 = log_data.size();
        cfg_send(64'd0, 6'd7);
        drain();
        chk("l0_count", 64'(log_data.size() - n0), 64'd1);
        if (log_data.size() > n0)
            chk512("l0_blk", log_data[n0], {1'b1, 447'd0, 64'd0});

        // L=1000 under random backpressure, wrong last marker on block 0
        msg[0] = rnd512();
        msg[1] = rnd512();
        n0 = log_data.size();
        e0 = err_seen;
        rand_rdy = 1'b1;
        cfg_send(64'd1000, 6'd42);
        blk_send(0, 1'b1);
        blk_send(1, 1'b1);
        drain();
        rand_rdy = 1'b0;
        repeat (2) @(negedge clk);
        chk("l1000_count", 64'(log_data.size() - n0), 64'd3);
        chk("l1000_err_pulses", 64'(err_seen - e0), 64'd1);
        if (log_data.size() > n0)
            chk512("l1000_blk1", log_data[n0], msg[0]);

        // sync_rst mid-message
        msg[0] = rnd512();
        cfg_send(64'd1536, 6'd11);
        blk_send(0, 1'b0);
        repeat (3) @(negedge clk);
        @(posedge clk); #1; sync_rst = 1'b1;
        @(posedge clk); #1; sync_rst = 1'b0;
        @(negedge clk);
        chk("srst_cfg_ready", 64'(cfg_ready), 64'd1);
        chk("srst_valid", 64'(data_out_valid), 64'd0);

        // nrst mid-message, then a fresh "abc"
        msg[0] = rnd512();
        cfg_send(64'd1536, 6'd12);
        blk_send(0, 1'b0);
        repeat (3) @(negedge clk);
        #1; nrst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midrst");
        @(posedge clk); #1; nrst = 1'b1;
        msg[0] = rnd512();
        msg[0][511:488] = 24'h616263;
        n0 = log_data.size();
        cfg_send(64'd24, 6'd21);
        blk_send(0, 1'b1);
        drain();
        chk("abc2_count", 64'(log_data.size() - n0), 64'd1);
        if (log_data.size() > n0)
            chk512("abc2_block", log_data[n0], {32'h61626380, 416'd0, 64'h18});
    endtask

    initial begin
        fork
            begin
                forever begin
                    @(negedge clk);
                    mon_step();
                end
            end
            begin
                main_seq();
                $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
                $finish;
            end
        join_any
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
